// File: rtl/debug_ctrl.sv
// Debug-bus command controller: decodes one command word per bus transaction,
// drives halt/step/register-access handshakes toward the harts, and returns a 64-bit status word.
module debug_ctrl #(
  parameter int BUS_ID    = 3,
  parameter int NUM_HARTS = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           bus_addr,
  input  logic                 bus_start,
  input  logic [63:0]          bus_wdata,
  output logic [63:0]          bus_rdata,
  output logic                 bus_rdata_oe,
  output logic                 bus_accepted,
  output logic                 bus_available,
  output logic [NUM_HARTS-1:0] hlt_req,
  input  logic [NUM_HARTS-1:0] hlt_state,
  output logic [NUM_HARTS-1:0] step_req,
  input  logic [NUM_HARTS-1:0] step_done,
  output logic [3:0]           dbg_hart,
  output logic                 dbg_reg_req,
  output logic                 dbg_reg_write,
  output logic [3:0]           dbg_reg_addr,
  output logic [31:0]          dbg_reg_wdata,
  input  logic [31:0]          dbg_reg_rdata,
  input  logic                 dbg_reg_ack
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] OP_STATUS = 8'd0;
  localparam logic [7:0] OP_HALT   = 8'd1;
  localparam logic [7:0] OP_RESUME = 8'd2;
  localparam logic [7:0] OP_STEP   = 8'd3;
  localparam logic [7:0] OP_REG_RD = 8'd4;
  localparam logic [7:0] OP_REG_WR = 8'd5;

  state_t                r_state;
  logic [7:0]            r_op;
  logic [3:0]            r_h;
  logic [3:0]            r_reg;
  logic [31:0]           r_wdata;
  logic                  r_err;
  logic                  r_reg_wr;
  logic [15:0]           r_cnt;
  logic [63:0]           r_resp;
  logic                  r_accepted;
  logic                  r_available;
  logic                  r_responded;
  logic                  r_reg_req;
  logic [NUM_HARTS-1:0]  r_hlt_req;
  logic [NUM_HARTS-1:0]  r_step_req;

  logic [15:0] w_hlt16;
  logic [15:0] w_step16;
  logic        w_hit;
  logic [7:0]  w_in_op;
  logic [3:0]  w_in_h;
  logic        w_in_err;
  logic        w_done;
  logic        w_timeout;
  logic [63:0] w_resp;
  logic        w_unused;

  assign w_unused = &{1'b0, bus_wdata[31:16]};

  // Zero-extend per-hart inputs so a 4-bit hart index can address them safely.
  always_comb begin
    w_hlt16  = '0;
    w_step16 = '0;
    w_hlt16[NUM_HARTS-1:0]  = hlt_state;
    w_step16[NUM_HARTS-1:0] = step_done;
  end

  assign w_hit   = bus_start && (bus_addr == 8'(BUS_ID));
  assign w_in_op = bus_wdata[7:0];
  assign w_in_h  = bus_wdata[11:8];

  always_comb begin
    w_in_err = 1'b0;
    if ({1'b0, w_in_h} >= 5'(NUM_HARTS)) w_in_err = 1'b1;
    if (w_in_op > OP_REG_WR) w_in_err = 1'b1;
    if ((w_in_op == OP_STEP || w_in_op == OP_REG_RD || w_in_op == OP_REG_WR) && !w_hlt16[w_in_h])
      w_in_err = 1'b1;
  end

  always_comb begin
    w_done = 1'b0;
    if (r_err) w_done = 1'b1;
    else begin
      case (r_op)
        OP_STATUS:            w_done = 1'b1;
        OP_HALT:              w_done = w_hlt16[r_h];
        OP_RESUME:            w_done = !w_hlt16[r_h];
        OP_STEP:              w_done = w_step16[r_h];
        OP_REG_RD, OP_REG_WR: w_done = dbg_reg_ack;
        default:              w_done = 1'b1;
      endcase
    end
  end

  // A genuine completion in the same cycle as the limit wins over the timeout.
  assign w_timeout = !w_done && ((r_cnt + 16'd1) == 16'(TIMEOUT));

  always_comb begin
    w_resp = '0;
    if (!w_done) w_resp[2:1] = 2'b11;
    else if (r_err) w_resp[1] = 1'b1;
    else begin
      w_resp[0] = 1'b1;
      if (r_op == OP_STATUS) w_resp[31:16] = w_hlt16;
      if (r_op == OP_REG_RD) w_resp[63:32] = dbg_reg_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_h         <= '0;
      r_reg       <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_cnt       <= '0;
      r_resp      <= '0;
      r_accepted  <= 1'b0;
      r_available <= 1'b0;
      r_responded <= 1'b0;
      r_reg_req   <= 1'b0;
      r_hlt_req   <= '1;
      r_step_req  <= '0;
    end else begin
      r_accepted  <= 1'b0;
      r_available <= 1'b0;
      r_step_req  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_op       <= w_in_op;
            r_h        <= w_in_h;
            r_reg      <= bus_wdata[15:12];
            r_wdata    <= bus_wdata[63:32];
            r_err      <= w_in_err;
            r_reg_wr   <= (w_in_op == OP_REG_WR);
            r_cnt      <= '0;
            r_accepted <= 1'b1;
            r_state    <= S_WAIT;
            // Erroneous commands never touch the hart side.
            if (!w_in_err) begin
              for (int i = 0; i < NUM_HARTS; i++) begin
                if (w_in_h == 4'(i)) begin
                  if (w_in_op == OP_HALT)   r_hlt_req[i]  <= 1'b1;
                  if (w_in_op == OP_RESUME) r_hlt_req[i]  <= 1'b0;
                  if (w_in_op == OP_STEP)   r_step_req[i] <= 1'b1;
                end
              end
              if (w_in_op == OP_REG_RD || w_in_op == OP_REG_WR) r_reg_req <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 16'd1;
          if (w_done || w_timeout) begin
            r_resp      <= w_resp;
            r_reg_req   <= 1'b0;
            r_available <= 1'b1;
            r_responded <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_rdata     = r_resp;
  assign bus_rdata_oe  = (bus_addr == 8'(BUS_ID)) && ((r_state != S_IDLE) || r_responded);
  assign bus_accepted  = r_accepted;
  assign bus_available = r_available;
  assign hlt_req       = r_hlt_req;
  assign step_req      = r_step_req;
  assign dbg_hart      = r_h;
  assign dbg_reg_req   = r_reg_req;
  assign dbg_reg_write = r_reg_wr;
  assign dbg_reg_addr  = r_reg;
  assign dbg_reg_wdata = r_wdata;

endmodule

// File: tb/tb_debug_ctrl.sv
// Scoreboard bench for debug_ctrl: expected responses are queued at issue time
// and compared by an independent monitor whenever bus_available pulses.
module tb_debug_ctrl;
  logic        clk;
  logic        rst;
  logic [7:0]  bus_addr;
  logic        bus_start;
  logic [63:0] bus_wdata;
  logic [63:0] bus_rdata;
  logic        bus_rdata_oe;
  logic        bus_accepted;
  logic        bus_available;
  logic [1:0]  hlt_req;
  logic [1:0]  hlt_state;
  logic [1:0]  step_req;
  logic [1:0]  step_done;
  logic [3:0]  dbg_hart;
  logic        dbg_reg_req;
  logic        dbg_reg_write;
  logic [3:0]  dbg_reg_addr;
  logic [31:0] dbg_reg_wdata;
  logic [31:0] dbg_reg_rdata;
  logic        dbg_reg_ack;

  debug_ctrl #(.BUS_ID(3), .NUM_HARTS(2), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .bus_addr(bus_addr), .bus_start(bus_start), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_rdata_oe(bus_rdata_oe),
    .bus_accepted(bus_accepted), .bus_available(bus_available),
    .hlt_req(hlt_req), .hlt_state(hlt_state),
    .step_req(step_req), .step_done(step_done),
    .dbg_hart(dbg_hart), .dbg_reg_req(dbg_reg_req), .dbg_reg_write(dbg_reg_write),
    .dbg_reg_addr(dbg_reg_addr), .dbg_reg_wdata(dbg_reg_wdata),
    .dbg_reg_rdata(dbg_reg_rdata), .dbg_reg_ack(dbg_reg_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int step_cnt = 0;
  int s;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (bus_available) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_resp: got %h expected no response", bus_rdata);
      end else begin
        chk("resp_data", bus_rdata, exp_q.pop_front());
      end
    end
    if (|step_req) step_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] addr, input logic [63:0] w);
    bus_addr  = addr;
    bus_wdata = w;
    bus_start = 1'b1;
    tick();
    bus_start = 1'b0;
    bus_addr  = 8'd3;
  endtask

  // n busy cycles with no response, then the response cycle
  task automatic expect_avail(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({nm, "_busy"}, bus_available, 0);
      tick();
    end
    @(negedge clk);
    chk({nm, "_avail"}, bus_available, 1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] err_cmds [3];
    err_cmds[0] = 64'h103;  // STEP to running hart 1
    err_cmds[1] = 64'h009;  // bad opcode
    err_cmds[2] = 64'h201;  // HALT to nonexistent hart 2

    rst = 1'b0; bus_addr = 8'd3; bus_start = 1'b0; bus_wdata = '0;
    hlt_state = 2'b11; step_done = '0; dbg_reg_rdata = '0; dbg_reg_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hlt_req", hlt_req, 2'b11);
    chk("rst_step_req", step_req, 0);
    chk("rst_reg_req", dbg_reg_req, 0);
    chk("rst_accepted", bus_accepted, 0);
    chk("rst_available", bus_available, 0);
    chk("rst_rdata", bus_rdata, 0);
    chk("rst_oe", bus_rdata_oe, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Strobe to another address
    send(8'd5, 64'h0);
    @(negedge clk);
    chk("wrong_addr_accept", bus_accepted, 0);
    tick();
    @(negedge clk);
    chk("wrong_addr_avail", bus_available, 0);
    tick();

    // STATUS h=0
    exp_q.push_back(64'h0000_0000_0003_0001);
    send(8'd3, 64'h0);
    @(negedge clk);
    chk("status_accept", bus_accepted, 1);
    chk("status_oe_wait", bus_rdata_oe, 1);
    tick();
    @(negedge clk);
    chk("status_accept_pulse", bus_accepted, 0);
    chk("status_avail", bus_available, 1);
    tick();
    @(negedge clk);
    chk("idle_oe_after_resp", bus_rdata_oe, 1);
    bus_addr = 8'd5;
    #1;
    chk("idle_oe_other_addr", bus_rdata_oe, 0);
    bus_addr = 8'd3;
    tick();

    // RESUME h=1, hart stops being halted three cycles later
    exp_q.push_back(64'h1);
    send(8'd3, 64'h102);
    @(negedge clk);
    chk("resume_hlt_req", hlt_req, 2'b01);
    chk("resume_busy0", bus_available, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("resume_busy", bus_available, 0);
      tick();
    end
    hlt_state = 2'b01;
    expect_avail(1, "resume");

    // REG_RD h=0 reg 7, ack after two cycles
    exp_q.push_back({32'hDEADBEEF, 32'h1});
    send(8'd3, 64'h7004);
    @(negedge clk);
    chk("rd_req", dbg_reg_req, 1);
    chk("rd_addr", dbg_reg_addr, 7);
    chk("rd_hart", dbg_hart, 0);
    chk("rd_write", dbg_reg_write, 0);
    tick();
    @(negedge clk);
    chk("rd_req_hold", dbg_reg_req, 1);
    tick();
    dbg_reg_ack = 1'b1; dbg_reg_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_req_ack_cycle", dbg_reg_req, 1);
    chk("rd_busy", bus_available, 0);
    tick();
    dbg_reg_ack = 1'b0; dbg_reg_rdata = '0;
    @(negedge clk);
    chk("rd_req_drop", dbg_reg_req, 0);
    chk("rd_avail", bus_available, 1);
    tick();

    // REG_WR h=0 reg 3
    exp_q.push_back(64'h1);
    send(8'd3, 64'h12345678_0000_3005);
    @(negedge clk);
    chk("wr_req", dbg_reg_req, 1);
    chk("wr_write", dbg_reg_write, 1);
    chk("wr_addr", dbg_reg_addr, 3);
    chk("wr_wdata", dbg_reg_wdata, 32'h12345678);
    tick();
    dbg_reg_ack = 1'b1;
    @(negedge clk);
    chk("wr_busy", bus_available, 0);
    tick();
    dbg_reg_ack = 1'b0;
    @(negedge clk);
    chk("wr_avail", bus_available, 1);
    chk("wr_req_drop", dbg_reg_req, 0);
    tick();

    // Error commands respond immediately with no hart-side activity
    for (int k = 0; k < 3; k++) begin
      s = step_cnt;
      exp_q.push_back(64'h2);
      send(8'd3, err_cmds[k]);
      @(negedge clk);
      chk("err_hlt_req", hlt_req, 2'b01);
      chk("err_reg_req", dbg_reg_req, 0);
      chk("err_step_req", step_req, 0);
      tick();
      @(negedge clk);
      chk("err_avail", bus_available, 1);
      tick();
      chk("err_no_step", step_cnt, s);
    end

    // Valid STEP h=0; a step_done for hart 1 must be ignored
    s = step_cnt;
    exp_q.push_back(64'h1);
    send(8'd3, 64'h003);
    @(negedge clk);
    chk("step_pulse", step_req, 2'b01);
    tick();
    step_done = 2'b10;
    @(negedge clk);
    chk("step_pulse_end", step_req, 0);
    chk("step_busy_other", bus_available, 0);
    tick();
    step_done = 2'b01;
    @(negedge clk);
    chk("step_busy", bus_available, 0);
    tick();
    step_done = 2'b00;
    @(negedge clk);
    chk("step_avail", bus_available, 1);
    tick();
    chk("step_one_pulse", step_cnt, s + 1);

    // HALT h=1 that never halts -> timeout after 4 WAIT cycles
    exp_q.push_back(64'h6);
    send(8'd3, 64'h101);
    @(negedge clk);
    chk("to_hlt_req", hlt_req, 2'b11);
    chk("to_busy0", bus_available, 0);
    tick();
    expect_avail(3, "timeout");
    chk("to_hlt_req_kept", hlt_req, 2'b11);

    // Second strobe during WAIT, then reset mid-WAIT
    hlt_state = 2'b00;
    send(8'd3, 64'h001);
    send(8'd3, 64'h000);
    @(negedge clk);
    chk("second_strobe_accept", bus_accepted, 0);
    chk("second_strobe_avail", bus_available, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_hlt_req", hlt_req, 2'b11);
    chk("mid_rst_step_req", step_req, 0);
    chk("mid_rst_reg_req", dbg_reg_req, 0);
    chk("mid_rst_accepted", bus_accepted, 0);
    chk("mid_rst_available", bus_available, 0);
    chk("mid_rst_rdata", bus_rdata, 0);
    chk("mid_rst_oe", bus_rdata_oe, 0);
    tick();
    tick();
    rst = 1'b1;
    hlt_state = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_avail", bus_available, 0);
      tick();
    end
    chk("post_rst_oe", bus_rdata_oe, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
